mos6502_alu_core: RTL

//  Clocked 6502 ALU core. Latches operands/opcode on start, computes the result and

---
 rtl/mos6502_alu_pkg.sv | 33 +++
 rtl/mos6502_bcd_adjust.sv | 38 +++
 rtl/mos6502_alu_core.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mos6502_alu_pkg.sv
// Shared definitions for the 6502 ALU core.
//   alu_op_t     : ALU operation encoding (5-7 reserved, produce 0x00 / no flags)
//   alu_state_t  : sequencing state of the core (ADJ only used in decimal builds)
//   ALU_W        : datapath width
//   BCD_LO_ADJ / BCD_HI_ADJ : decimal correction constants
//   add9()       : 9-bit add with carry-in, bit 8 is the carry out
package mos6502_alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    OP_SUM = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_SR  = 3'd4
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADJ  = 1'b1
  } alu_state_t;

  localparam logic [ALU_W-1:0] BCD_LO_ADJ = 8'h06;
  localparam logic [ALU_W-1:0] BCD_HI_ADJ = 8'h60;

  function automatic logic [ALU_W:0] add9(input logic [ALU_W-1:0] a,
                                          input logic [ALU_W-1:0] b,
                                          input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/mos6502_bcd_adjust.sv
// Combinational decimal correction of a binary add result.
// Ports:
//   bin_r [7:0] in  : binary sum
//   bin_c       in  : binary carry out of bit 7
//   bin_h       in  : binary carry out of bit 3
//   adj_r [7:0] out : decimal-corrected sum
//   adj_c       out : decimal carry
// Only instantiated when MOS6502_DECIMAL_MODE_EN is defined.
module mos6502_bcd_adjust
  import mos6502_alu_pkg::*;
(
  input  logic [ALU_W-1:0] bin_r,
  input  logic             bin_c,
  input  logic             bin_h,
  output logic [ALU_W-1:0] adj_r,
  output logic             adj_c
);

  logic [ALU_W:0] lo_fix;
  logic           c_mid;

  always_comb begin
    lo_fix = {1'b0, bin_r};
    if ((bin_r[3:0] > 4'd9) || bin_h)
      lo_fix = lo_fix + {1'b0, BCD_LO_ADJ};
    // The low-nibble fix can itself ripple past bit 7 (e.g. 0xFA), which
    // counts as a decimal carry just like the binary one.
    c_mid = bin_c | lo_fix[ALU_W];
    // High nibble is judged after the low fix so 0x9A becomes 0xA0 -> 0x00.
    adj_r = lo_fix[ALU_W-1:0];
    adj_c = c_mid;
    if ((lo_fix[7:4] > 4'd9) || c_mid) begin
      adj_r = lo_fix[ALU_W-1:0] + BCD_HI_ADJ;
      adj_c = 1'b1;
    end
  end

endmodule

// File: rtl/mos6502_alu_core.sv
// Clocked 6502 ALU core.
// Captures operands/opcode when start is high, presents the result on alu_out
// with carry/overflow/half-carry and pulses valid for one cycle.
// Ports:
//   phi2            in       : clock, all state on posedge
//   reset           in       : asynchronous active-high reset
//   start           in       : capture operands this cycle (ignored while busy)
//   a_in, b_in      in  [7:0]: operands (b pre-inverted by caller for SBC)
//   op              in  [2:0]: alu_op_t
//   carry_in        in       : carry into SUM, shift-in bit for SR
//   decimal         in       : request BCD adjust of SUM
//   busy            out      : high while the decimal adjust cycle is active
//   valid           out      : one-cycle pulse when results update
//   alu_out         out [7:0]: result, held until the next result
//   carry_out, overflow_out, half_carry_out out : result flags
// Build option: MOS6502_DECIMAL_MODE_EN enables the decimal adjust (ADJ) cycle.
// Without it (2A03 build) decimal is ignored, busy is 0 and latency is always 1.
// Handshake: start is accepted on a posedge only when busy is low; valid is
// high for exactly the one cycle after results are registered and carries no
// back-pressure (the consumer must take alu_out while valid or later, it holds).
module mos6502_alu_core
  import mos6502_alu_pkg::*;
(
  input  logic             phi2,
  input  logic             reset,
  input  logic             start,
  input  logic [ALU_W-1:0] a_in,
  input  logic [ALU_W-1:0] b_in,
  input  logic [2:0]       op,
  input  logic             carry_in,
  input  logic             decimal,
  output logic             busy,
  output logic             valid,
  output logic [ALU_W-1:0] alu_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             half_carry_out
);

  // Binary stage, evaluated straight from the inputs.
  logic [ALU_W:0]   sum9;
  logic [ALU_W-1:0] bin_r;
  logic             bin_c, bin_v, bin_h;

  always_comb begin
    sum9  = add9(a_in, b_in, carry_in);
    bin_r = '0;
    bin_c = 1'b0;
    bin_v = 1'b0;
    bin_h = 1'b0;
    case (op)
      OP_SUM: begin
        bin_r = sum9[ALU_W-1:0];
        bin_c = sum9[ALU_W];
        bin_v = (a_in[7] == b_in[7]) && (sum9[7] != a_in[7]);
        // Carry into bit 4 is recovered from the sum bit and the operand bits.
        bin_h = sum9[4] ^ a_in[4] ^ b_in[4];
      end
      OP_AND: bin_r = a_in & b_in;
      OP_OR:  bin_r = a_in | b_in;
      OP_XOR: bin_r = a_in ^ b_in;
      OP_SR: begin
        bin_r = {carry_in, a_in[7:1]};
        bin_c = a_in[0];
      end
      default: ; // reserved: zero result, no flags
    endcase
  end

  logic [ALU_W-1:0] out_q, out_d;
  logic             c_q, c_d, v_q, v_d, h_q, h_d;
  logic             valid_q, valid_d;

`ifdef MOS6502_DECIMAL_MODE_EN
  alu_state_t       state_q, state_d;
  // Binary result parked for the adjust cycle.
  logic [ALU_W-1:0] hold_r_q, hold_r_d;
  logic             hold_c_q, hold_c_d, hold_v_q, hold_v_d, hold_h_q, hold_h_d;
  logic [ALU_W-1:0] adj_r;
  logic             adj_c;

  mos6502_bcd_adjust u_bcd (
    .bin_r (hold_r_q),
    .bin_c (hold_c_q),
    .bin_h (hold_h_q),
    .adj_r (adj_r),
    .adj_c (adj_c)
  );

  always_comb begin
    state_d  = state_q;
    hold_r_d = hold_r_q;
    hold_c_d = hold_c_q;
    hold_v_d = hold_v_q;
    hold_h_d = hold_h_q;
    out_d    = out_q;
    c_d      = c_q;
    v_d      = v_q;
    h_d      = h_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((op == OP_SUM) && decimal) begin
            state_d  = ST_ADJ;
            hold_r_d = bin_r;
            hold_c_d = bin_c;
            hold_v_d = bin_v;
            hold_h_d = bin_h;
          end else begin
            out_d   = bin_r;
            c_d     = bin_c;
            v_d     = bin_v;
            h_d     = bin_h;
            valid_d = 1'b1;
          end
        end
      end
      ST_ADJ: begin
        // start is deliberately not looked at here.
        out_d   = adj_r;
        c_d     = adj_c;
        v_d     = hold_v_q;
        h_d     = hold_h_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hold_r_q <= '0;
      hold_c_q <= 1'b0;
      hold_v_q <= 1'b0;
      hold_h_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_r_q <= hold_r_d;
      hold_c_q <= hold_c_d;
      hold_v_q <= hold_v_d;
      hold_h_q <= hold_h_d;
    end
  end

  assign busy = (state_q == ST_ADJ);
`else
  logic unused_decimal;
  assign unused_decimal = decimal;

  always_comb begin
    out_d   = out_q;
    c_d     = c_q;
    v_d     = v_q;
    h_d     = h_q;
    valid_d = 1'b0;
    if (start) begin
      out_d   = bin_r;
      c_d     = bin_c;
      v_d     = bin_v;
      h_d     = bin_h;
      valid_d = 1'b1;
    end
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      h_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      c_q     <= c_d;
      v_q     <= v_d;
      h_q     <= h_d;
      valid_q <= valid_d;
    end
  end

  assign alu_out        = out_q;
  assign carry_out      = c_q;
  assign overflow_out   = v_q;
  assign half_carry_out = h_q;
  assign valid          = valid_q;

endmodule
